// File: rtl/regfile_wr_arbiter_pkg.sv
// Shared processor definitions for the register-file write arbiter:
// register/data widths, arbiter state encoding and the default starvation limit.
package regfile_wr_arbiter_pkg;

    localparam int unsigned REG_AW   = 3;
    localparam int unsigned DATA_W   = 8;
    localparam int unsigned NUM_REGS = 1 << REG_AW;

    localparam int unsigned STARVE_LIMIT_DEFAULT = 4;

    typedef enum logic [1:0] {
        IDLE,
        HOLD,
        FORCE
    } arb_state_t;

    function automatic logic [NUM_REGS-1:0] rd_onehot(input logic [REG_AW-1:0] rd);
        return NUM_REGS'(1) << rd;
    endfunction

endpackage

// File: rtl/regfile_wr_arbiter_if.sv
// Writeback, aux-requester and register-file write signals of the arbiter;
// master drives the requests, slave is the arbiter itself.
interface regfile_wr_arbiter_if;
    import regfile_wr_arbiter_pkg::*;

    logic                wb_we;
    logic [REG_AW-1:0]   wb_rd;
    logic [DATA_W-1:0]   wb_data;
    logic                aux_valid;
    logic [REG_AW-1:0]   aux_rd;
    logic [DATA_W-1:0]   aux_data;
    logic                aux_ready;
    logic                rf_we;
    logic [REG_AW-1:0]   rf_wa;
    logic [DATA_W-1:0]   rf_wd;
    logic                pipe_stall;
    logic [NUM_REGS-1:0] busy_mask;

    modport master (
        output wb_we, wb_rd, wb_data, aux_valid, aux_rd, aux_data,
        input  aux_ready, rf_we, rf_wa, rf_wd, pipe_stall, busy_mask
    );

    modport slave (
        input  wb_we, wb_rd, wb_data, aux_valid, aux_rd, aux_data,
        output aux_ready, rf_we, rf_wa, rf_wd, pipe_stall, busy_mask
    );

endinterface

// File: rtl/regfile_wr_arbiter.sv
// Register-file write-port arbiter: writeback always wins, a one-entry aux holding
// register waits for a free slot and forces a pipeline bubble when starved.
module regfile_wr_arbiter
    import regfile_wr_arbiter_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst_n,
    regfile_wr_arbiter_if.slave  bus
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    arb_state_t          state;
    logic [REG_AW-1:0]   held_rd;
    logic [DATA_W-1:0]   held_data;
    logic [3:0]          wait_cnt;
    logic [3:0]          wait_inc;

    logic                rf_we_q;
    logic [REG_AW-1:0]   rf_wa_q;
    logic [DATA_W-1:0]   rf_wd_q;
    logic                stall_q;
    logic [NUM_REGS-1:0] busy_q;

    always_comb begin
        wait_inc = (wait_cnt == '1) ? wait_cnt : wait_cnt + 4'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            held_rd   <= '0;
            held_data <= '0;
            wait_cnt  <= '0;
            rf_we_q   <= 1'b0;
            rf_wa_q   <= '0;
            rf_wd_q   <= '0;
            stall_q   <= 1'b0;
            busy_q    <= '0;
        end else begin
            rf_we_q <= 1'b0;
            stall_q <= 1'b0;

            if (bus.wb_we) begin
                rf_we_q <= 1'b1;
                rf_wa_q <= bus.wb_rd;
                rf_wd_q <= bus.wb_data;
            end

            unique case (state)
                IDLE: begin
                    if (bus.aux_valid) begin
                        held_rd   <= bus.aux_rd;
                        held_data <= bus.aux_data;
                        wait_cnt  <= '0;
                        busy_q    <= rd_onehot(bus.aux_rd);
                        state     <= HOLD;
                    end
                end
                HOLD, FORCE: begin
                    if (!bus.wb_we) begin
                        rf_we_q <= 1'b1;
                        rf_wa_q <= held_rd;
                        rf_wd_q <= held_data;
                        busy_q  <= '0;
                        state   <= IDLE;
                    end else if (bus.wb_rd == held_rd) begin
                        // WB carries newer data for the same register: drop the held write
                        busy_q <= '0;
                        state  <= IDLE;
                    end else begin
                        wait_cnt <= wait_inc;
                        if (state == FORCE || wait_inc >= LIMIT) begin
                            stall_q <= 1'b1;
                            state   <= FORCE;
                        end
                    end
                end
                default: begin
                    busy_q <= '0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    assign bus.aux_ready  = (state == IDLE);
    assign bus.rf_we      = rf_we_q;
    assign bus.rf_wa      = rf_wa_q;
    assign bus.rf_wd      = rf_wd_q;
    assign bus.pipe_stall = stall_q;
    assign bus.busy_mask  = busy_q;

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Randomized self-checking bench for regfile_wr_arbiter against a queue-based
// model of the write-port rules, plus directed scenarios.
module tb_regfile_wr_arbiter;

    localparam int unsigned LIMIT = 4;

    logic clk;
    logic rst_n;

    regfile_wr_arbiter_if bus ();

    regfile_wr_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] rd;
        logic [7:0] data;
        int         waits;
    } held_t;

    held_t      mdl_q[$];
    logic       exp_we;
    logic [2:0] exp_wa;
    logic [7:0] exp_wd;
    logic       exp_stall;
    logic [7:0] exp_busy;

    int n_checks;
    int n_errors;

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic drive(input logic we, input logic [2:0] rd, input logic [7:0] data,
                         input logic av, input logic [2:0] ard, input logic [7:0] adata);
        bus.wb_we     = we;
        bus.wb_rd     = rd;
        bus.wb_data   = data;
        bus.aux_valid = av;
        bus.aux_rd    = ard;
        bus.aux_data  = adata;
    endtask

    // Predict the outcome of the coming edge from current inputs, then compare after it.
    task automatic step();
        check("aux_ready", bus.aux_ready, (mdl_q.size() == 0) ? 1 : 0);
        exp_we    = 1'b0;
        exp_stall = 1'b0;
        if (bus.wb_we) begin
            exp_we = 1'b1;
            exp_wa = bus.wb_rd;
            exp_wd = bus.wb_data;
        end
        if (mdl_q.size() == 0) begin
            if (bus.aux_valid)
                mdl_q.push_back('{rd: bus.aux_rd, data: bus.aux_data, waits: 0});
        end else if (!bus.wb_we) begin
            exp_we = 1'b1;
            exp_wa = mdl_q[0].rd;
            exp_wd = mdl_q[0].data;
            void'(mdl_q.pop_front());
        end else if (bus.wb_rd == mdl_q[0].rd) begin
            void'(mdl_q.pop_front());
        end else begin
            mdl_q[0].waits++;
            if (mdl_q[0].waits >= LIMIT) exp_stall = 1'b1;
        end
        exp_busy = (mdl_q.size() != 0) ? (8'd1 << mdl_q[0].rd) : 8'd0;

        @(posedge clk);
        #1;
        check("rf_we", bus.rf_we, exp_we);
        check("rf_wa", bus.rf_wa, exp_wa);
        check("rf_wd", bus.rf_wd, exp_wd);
        check("pipe_stall", bus.pipe_stall, exp_stall);
        check("busy_mask", bus.busy_mask, exp_busy);
    endtask

    task automatic model_reset();
        mdl_q.delete();
        exp_we = 1'b0; exp_wa = '0; exp_wd = '0; exp_stall = 1'b0; exp_busy = '0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rf_we"}, bus.rf_we, 0);
        check({tag, "_rf_wa"}, bus.rf_wa, 0);
        check({tag, "_rf_wd"}, bus.rf_wd, 0);
        check({tag, "_stall"}, bus.pipe_stall, 0);
        check({tag, "_busy"}, bus.busy_mask, 0);
        check({tag, "_ready"}, bus.aux_ready, 1);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        model_reset();
        drive(0, 0, 0, 0, 0, 0);
        rst_n = 1'b0;
        #12;
        check_reset_outputs("reset");
        #1 rst_n = 1'b1;

        // WB only: one-cycle latency, aux path stays ready
        drive(1, 3, 8'h5A, 0, 0, 0);
        step();
        check("wb_only_wd", bus.rf_wd, 8'h5A);
        drive(0, 0, 0, 0, 0, 0);
        step();

        // Aux with idle pipeline: held one cycle, then committed
        drive(0, 0, 0, 1, 2, 8'h11);
        step();
        check("aux_busy", bus.busy_mask, 8'h04);
        drive(0, 0, 0, 0, 0, 0);
        step();
        check("aux_commit_wd", bus.rf_wd, 8'h11);

        // Starvation: stall after LIMIT waiting cycles, commit on the bubble
        drive(0, 0, 0, 1, 5, 8'h77);
        step();
        for (int i = 0; i < LIMIT; i++) begin
            drive(1, 3'(i), 8'(i + 8'h40), 0, 0, 0);
            step();
        end
        check("starve_stall", bus.pipe_stall, 1);
        drive(0, 0, 0, 0, 0, 0);
        step();
        check("starve_commit_wa", bus.rf_wa, 5);

        // Squash: newer WB to the same register replaces the held write
        drive(0, 0, 0, 1, 6, 8'h22);
        step();
        drive(1, 6, 8'h33, 0, 0, 0);
        step();
        check("squash_wd", bus.rf_wd, 8'h33);
        drive(0, 0, 0, 0, 0, 0);
        step();
        check("squash_idle", bus.aux_ready, 1);

        // Reset while an aux write to r4 is held
        drive(0, 0, 0, 1, 4, 8'h99);
        step();
        check("pre_reset_busy", bus.busy_mask, 8'h10);
        drive(1, 1, 8'h01, 0, 0, 0);
        #2 rst_n = 1'b0;
        #1;
        check_reset_outputs("midhold");
        model_reset();
        #2 rst_n = 1'b1;
        drive(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) step();

        // Random traffic; usually honour a stall request, sometimes violate it
        for (int i = 0; i < 3000; i++) begin
            logic we;
            if (bus.pipe_stall)
                we = ($urandom_range(0, 3) == 0);
            else
                we = ($urandom_range(0, 9) < 7);
            drive(we, 3'($urandom_range(0, 7)), 8'($urandom),
                  1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 8'($urandom));
            step();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/regfile_wr_arbiter.md
REGFILE_WR_ARBITER -- requirements
Module: regfile_wr_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, default 4, cycles an aux write may wait in HOLD before a pipeline stall is forced (range 1..15).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 wb_we  input  1  writeback-stage register-write request (pipeline WB regWrite).
REQ-005 wb_rd  input  3  writeback destination register number.
REQ-006 wb_data  input  8  writeback data (WB mux output).
REQ-007 aux_valid  input  1  secondary requester (multi-cycle/IO unit) write request.
REQ-008 aux_rd  input  3  aux destination register number.
REQ-009 aux_data  input  8  aux write data.
REQ-010 aux_ready  output  1  aux request accepted this cycle when aux_valid and aux_ready both high.
REQ-011 rf_we  output  1  registered register-file write enable.
REQ-012 rf_wa  output  3  registered register-file write address.
REQ-013 rf_wd  output  8  registered register-file write data.
REQ-014 pipe_stall  output  1  registered request to pipeline: insert a bubble so wb_we is 0 in the following cycle.
REQ-015 busy_mask  output  8  bit n high while an aux write to register n is held, not yet committed.

Function
REQ-016 WB has absolute priority; a WB request is never delayed or dropped; latency wb_we -> rf_we is exactly 1 cycle.
REQ-017 Aux path has a one-entry holding register; aux_ready = 1 only in state IDLE (combinational from state).
REQ-018 States: IDLE (holding empty), HOLD (holding full, waiting), FORCE (pipe_stall asserted, waiting for bubble).
REQ-019 IDLE: aux handshake -> capture aux_rd/aux_data, go HOLD, clear wait counter; no bypass, an accepted aux write commits no earlier than the next cycle.
REQ-020 HOLD: wb_we = 0 -> commit held entry on rf_* next cycle, go IDLE; wb_we = 1 -> increment wait counter (4 bits, saturating).
REQ-021 HOLD: when wait counter reaches STARVE_LIMIT with wb_we = 1, assert pipe_stall for exactly one cycle, go FORCE.
REQ-022 FORCE: commit held entry in the first cycle with wb_we = 0, go IDLE; if wb_we stays 1 (pipeline violated contract), remain FORCE and re-assert pipe_stall every cycle.
REQ-023 Squash: in HOLD or FORCE, wb_we = 1 with wb_rd equal to held rd -> held entry discarded (WB is newer), WB write proceeds, go IDLE, no pipe_stall that cycle.
REQ-024 rf_we = 0 in any cycle with neither a WB write nor an aux commit; rf_wa/rf_wd hold previous values when rf_we = 0.
REQ-025 busy_mask is one-hot of held rd in HOLD/FORCE, all-zero in IDLE; updates same edge as state.
REQ-026 At most one register-file write per cycle; aux write never overwrites a WB write issued later.

Reset
REQ-027 rst_n low asynchronously forces: state IDLE, wait counter 0, holding entry invalid, rf_we 0, rf_wa 0, rf_wd 0x00, pipe_stall 0, busy_mask 0x00.
REQ-028 Reset mid-HOLD/FORCE discards the held entry; it is never committed.
REQ-029 First rising clk edge after rst_n deasserts may accept an aux request.

Structure
REQ-030 Shared processor package holds: register-number width (3), data width (8), state enum {IDLE, HOLD, FORCE}, STARVE_LIMIT default.
REQ-031 Single module, no sub-modules; the holding register is inline.

Verification
REQ-032 WB only: wb_we=1, wb_rd=3, wb_data=0x5A -> next cycle rf_we=1, rf_wa=3, rf_wd=0x5A; aux_ready stays 1.
REQ-033 Aux idle pipe: aux_valid=1, rd=2, data=0x11, wb_we=0 -> busy_mask=0x04 one cycle, then rf_we=1, rf_wa=2, rf_wd=0x11, busy_mask=0x00.
REQ-034 Starvation: aux accepted (rd=5), wb_we=1 continuously -> pipe_stall high exactly one cycle after 4 waiting cycles; wb_we=0 next -> aux commit rd=5.
REQ-035 Squash: aux held rd=6 data=0x22, then wb_we=1 rd=6 data=0x33 -> only rf_wd=0x33 written to 6; 0x22 never appears; state IDLE.
REQ-036 Reset mid-HOLD: rst_n low while busy_mask=0x10 -> all outputs zero immediately; after release no write to register 4 occurs.
